// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared types for the store buffer: the default-width queued store entry and
// the drain FSM state encoding.
// -----------------------------------------------------------------------------
package store_buffer_pkg;

   localparam int SB_AW  = 32;
   localparam int SB_DW  = 32;
   localparam int SB_BEW = 4;

   typedef struct packed {
      logic [SB_AW-1:0]  addr;
      logic [SB_DW-1:0]  data;
      logic [SB_BEW-1:0] be;
   } sb_entry_t;

   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_REQ  = 1'b1
   } sb_state_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// In-order storage for committed stores. Pointers carry one wrap bit so a full
// buffer and an empty one are told apart without a separate counter register.
// Ports:
//   clk, reset   clock / asynchronous active-low reset (pointers only)
//   push_i       write din_i at the tail this edge
//   pop_i        retire the head entry this edge
//   din_i        entry to enqueue
//   head_o       oldest entry (combinational read)
//   entries_o    every storage slot, for alias checks
//   valid_o      per-slot occupancy
//   count_o      number of occupied slots, 0..DEPTH
//   full_o       all slots occupied
//   empty_o      no slot occupied
// -----------------------------------------------------------------------------
module sb_fifo
   import store_buffer_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type ENTRY_T = sb_entry_t,
   localparam int PW      = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push_i,
   input  logic           pop_i,
   input  ENTRY_T         din_i,
   output ENTRY_T         head_o,
   output ENTRY_T         entries_o [DEPTH],
   output logic [DEPTH-1:0] valid_o,
   output logic [PW:0]    count_o,
   output logic           full_o,
   output logic           empty_o
);

   ENTRY_T       mem_q [DEPTH];
   logic [PW:0]  wr_ptr_q, wr_ptr_d;
   logic [PW:0]  rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_i};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_i};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; occupancy is defined purely by the pointers.
   // A push into a full buffer is only legal together with a pop, in which
   // case the tail slot is the head slot being vacated at this same edge.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q[PW-1:0]] <= din_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);

   // A slot is occupied when its distance from the head is below the count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [PW-1:0] offset;
      assign offset       = PW'(i) - rd_ptr_q[PW-1:0];
      assign valid_o[i]   = ({1'b0, offset} < count_o);
      assign entries_o[i] = mem_q[i];
   end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Queues committed stores from retire and drains them in order to data memory
// over a req/ack handshake. Back-pressures retire when full and flags loads
// whose word address aliases a pending or incoming store.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low
//   write      byte enables from retire; non-zero means a store this cycle
//   wr_addr    store address
//   wr_data    store data
//   stall      buffer cannot accept a store this cycle (combinational)
//   ld_addr    address of the load in execute
//   ld_hit     load word aliases a pending or incoming store (combinational)
//   mem_req    registered store request to memory
//   mem_addr   head entry address
//   mem_data   head entry data
//   mem_be     head entry byte enables
//   mem_ack    memory accepted the current request
//   empty      no pending stores and no request outstanding
//   overflow   sticky: a store arrived while stall was high
// -----------------------------------------------------------------------------
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    write,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          stall,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic [3:0]    mem_be,
   input  logic          mem_ack,
   output logic          empty,
   output logic          overflow
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [3:0]    be;
   } entry_t;

   sb_state_t        state_q;
   logic             mem_req_q;
   logic             overflow_q;

   entry_t           din;
   entry_t           head;
   entry_t           entries [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW:0]      count;
   logic             fifo_full;
   logic             fifo_empty;

   logic             store_vld;
   logic             pop;
   logic             push;
   logic             unused_bits;

   assign store_vld = |write;

   // mem_ack is only meaningful while a request is outstanding.
   assign pop   = (state_q == SB_REQ) && mem_ack;

   // A full buffer can still take a store on the edge that frees the head.
   assign stall = fifo_full && !pop;
   assign push  = store_vld && !stall;

   assign din = '{addr: wr_addr, data: wr_data, be: write};

   sb_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (push),
      .pop_i     (pop),
      .din_i     (din),
      .head_o    (head),
      .entries_o (entries),
      .valid_o   (valid),
      .count_o   (count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // Drain FSM. mem_req is registered, so a store enqueued at edge N is
   // first requested after edge N+1. On an ack, the FSM stays in REQ when
   // anything remains after the pop (older entries or a same-edge enqueue),
   // giving one pop per cycle with no idle bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SB_IDLE;
         mem_req_q <= 1'b0;
      end else begin
         case (state_q)
            SB_IDLE: begin
               if (!fifo_empty) begin
                  state_q   <= SB_REQ;
                  mem_req_q <= 1'b1;
               end
            end
            SB_REQ: begin
               if (mem_ack && !((count > (PW+1)'(1)) || push)) begin
                  state_q   <= SB_IDLE;
                  mem_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= SB_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (store_vld && stall) begin
         overflow_q <= 1'b1;
      end
   end

   // Alias check at word granularity; byte enables are deliberately ignored
   // so partial-word overlaps are always reported.
   always_comb begin
      ld_hit = store_vld && (wr_addr[AW-1:2] == ld_addr[AW-1:2]);
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (entries[i].addr[AW-1:2] == ld_addr[AW-1:2])) begin
            ld_hit = 1'b1;
         end
      end
   end

   // Byte offsets and non-address entry fields take no part in the alias check.
   always_comb begin
      unused_bits = ^ld_addr[1:0];
      for (int i = 0; i < DEPTH; i++) begin
         unused_bits = unused_bits ^ (^entries[i]);
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = head.addr;
   assign mem_data = head.data;
   assign mem_be   = head.be;
   assign empty    = fifo_empty && (state_q == SB_IDLE);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  write;
   logic [31:0] wr_addr, wr_data, ld_addr;
   logic        stall, ld_hit, mem_req, mem_ack, empty, overflow;
   logic [31:0] mem_addr, mem_data;
   logic [3:0]  mem_be;

   store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .write    (write),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .stall    (stall),
      .ld_addr  (ld_addr),
      .ld_hit   (ld_hit),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_be   (mem_be),
      .mem_ack  (mem_ack),
      .empty    (empty),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } st_t;

   // Reference model: pending stores as a plain queue, plus whether a
   // memory request is outstanding and the sticky overflow flag.
   st_t mdl[$];
   st_t exp_q[$];
   bit  m_req;
   bit  m_ovf;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle against the
   // model, then advance the model across the rising edge.
   task automatic cycle(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                        input logic ack, input logic [31:0] ld);
      int  size;
      bit  pop, full, exp_stall, acc, exp_hit, n_req;
      write = be; wr_addr = a; wr_data = d; mem_ack = ack; ld_addr = ld;
      @(negedge clk);
      size      = mdl.size();
      pop       = m_req && ack;
      full      = (size == DEPTH);
      exp_stall = full && !pop;
      acc       = (be != 4'h0) && !exp_stall;
      exp_hit   = (be != 4'h0) && (a[31:2] == ld[31:2]);
      foreach (mdl[i]) if (mdl[i].addr[31:2] == ld[31:2]) exp_hit = 1'b1;
      chk("stall",    {31'b0, stall},    {31'b0, exp_stall});
      chk("ld_hit",   {31'b0, ld_hit},   {31'b0, exp_hit});
      chk("empty",    {31'b0, empty},    {31'b0, (size == 0) && !m_req});
      chk("mem_req",  {31'b0, mem_req},  {31'b0, m_req});
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      if (m_req) begin
         chk("held_addr", mem_addr, mdl[0].addr);
         chk("held_data", mem_data, mdl[0].data);
         chk("held_be",   {28'b0, mem_be}, {28'b0, mdl[0].be});
      end
      if (acc) exp_q.push_back('{a, d, be});
      // After an edge a request is outstanding whenever something was pending
      // before it, unless the last entry was just acknowledged with nothing new.
      if (m_req) n_req = !pop || (size > 1) || acc;
      else       n_req = (size > 0);
      @(posedge clk);
      #1;
      if (pop) mdl.delete(0);
      if (acc) mdl.push_back('{a, d, be});
      m_req = n_req;
      if ((be != 4'h0) && exp_stall) m_ovf = 1'b1;
   endtask

   task automatic idle(input int n, input logic ack);
      for (int k = 0; k < n; k++) cycle(4'h0, 32'h0, 32'h0, ack, 32'hFFFF_FFF0);
   endtask

   // Asynchronous reset asserted between clock edges; outputs must clear at once.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      chk("rst_mem_req",  {31'b0, mem_req},  32'd0);
      chk("rst_empty",    {31'b0, empty},    32'd1);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
      chk("rst_stall",    {31'b0, stall},    32'd0);
      mdl.delete();
      exp_q.delete();
      m_req = 1'b0;
      m_ovf = 1'b0;
      write = 4'h0;
      mem_ack = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every accepted memory transaction must be the
   // oldest store still expected.
   always @(negedge clk) begin
      st_t e;
      if (reset === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected: got addr %h expected no transaction", mem_addr);
         end else begin
            e = exp_q.pop_front();
            chk("drain_addr", mem_addr, e.addr);
            chk("drain_data", mem_data, e.data);
            chk("drain_be",   {28'b0, mem_be}, {28'b0, e.be});
         end
      end
   end

   initial begin
      reset = 1'b0; write = 4'h0; wr_addr = '0; wr_data = '0; ld_addr = '0; mem_ack = 1'b0;
      m_req = 1'b0; m_ovf = 1'b0;
      #1;
      chk("init_mem_req",  {31'b0, mem_req},  32'd0);
      chk("init_empty",    {31'b0, empty},    32'd1);
      chk("init_overflow", {31'b0, overflow}, 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;

      // Single store, ack two cycles after the request rises.
      cycle(4'hF, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
      idle(3, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);

      // Fill to full, fifth store dropped, drain in order.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(4'hF, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 32'h0);
      cycle(4'hF, 32'h10, 32'hBAD0_0005, 1'b0, 32'h0);
      idle(1, 1'b0);
      idle(6, 1'b1);

      // Full with ack and a new store in the same cycle.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(4'h3, 32'h40 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
      idle(1, 1'b0);
      cycle(4'hF, 32'h10, 32'h1234_5678, 1'b1, 32'h0);
      idle(1, 1'b0);
      idle(6, 1'b1);

      // Back-to-back stores with ack held high.
      do_reset();
      cycle(4'hF, 32'h20, 32'h1111_1111, 1'b1, 32'h0);
      cycle(4'hC, 32'h24, 32'h2222_2222, 1'b1, 32'h0);
      cycle(4'h1, 32'h28, 32'h3333_3333, 1'b1, 32'h0);
      idle(5, 1'b1);

      // Load aliasing.
      do_reset();
      cycle(4'h1, 32'h200, 32'h0000_00AA, 1'b0, 32'h0);
      cycle(4'h0, 32'h0, 32'h0, 1'b0, 32'h203);
      cycle(4'h0, 32'h0, 32'h0, 1'b0, 32'h204);
      cycle(4'hF, 32'h300, 32'h0000_0BBB, 1'b0, 32'h300);
      idle(4, 1'b1);

      // Reset mid-request with three entries, then normal operation.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(4'hF, 32'h500 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b0, 32'h0);
      idle(2, 1'b0);
      do_reset();
      cycle(4'hF, 32'h400, 32'h4444_4444, 1'b0, 32'h0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);

      // Randomized traffic on a small address window to provoke aliasing.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [3:0]  be;
         logic [31:0] a, d, ld;
         logic        ack;
         be  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         a   = 32'($urandom_range(0, 63));
         d   = $urandom;
         ld  = 32'($urandom_range(0, 63));
         ack = 1'($urandom_range(0, 1));
         cycle(be, a, d, ack, ld);
      end
      idle(8, 1'b1);
      chk("all_drained", 32'(exp_q.size()), 32'd0);
      chk("model_empty", 32'(mdl.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
